// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and sizes for the hazard scoreboard: register-file geometry,
// pending-counter width and the two-state stall controller encoding.
package hazard_scoreboard_pkg;

   localparam int NREG = 8;
   localparam int AW   = $clog2(NREG);
   localparam int CNTW = 2;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MEMWAIT = 1'b1
   } state_e;

   localparam logic [0:0] ST_RUN     = RUN;
   localparam logic [0:0] ST_MEMWAIT = MEMWAIT;

   localparam logic [CNTW-1:0] CNT_MAX = '1;

endpackage

// File: rtl/hazard_scoreboard_pend_counter.sv
// One pending-write counter: counts in-flight writers of a single register,
// saturating at full scale and never wrapping below zero.
module pend_counter
   import hazard_scoreboard_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic nonzero
);

   logic [CNTW-1:0] cnt_q;
   logic [CNTW-1:0] cnt_d;

   // Simultaneous inc and dec cancel; out-of-range steps are dropped.
   always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end else if (dec && !inc && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard: per-register pending writes plus the
// IF/ID/EX stall, bubble and flush controls. HAZARD_PERF_EN adds perf counters.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
(
   input  logic            CLK,
   input  logic            Reset,
   input  logic            id_valid,
   input  logic [AW-1:0]   id_rs1,
   input  logic [AW-1:0]   id_rs2,
   input  logic [AW-1:0]   id_rd,
   input  logic            id_use_rs1,
   input  logic            id_use_rs2,
   input  logic            id_wr,
   input  logic            id_is_branch,
   input  logic            ex_valid,
   input  logic            ex_is_load,
   input  logic [AW-1:0]   ex_rd,
   input  logic            mem_is_load,
   input  logic [AW-1:0]   mem_rd,
   input  logic            mem_req,
   input  logic            mem_ready,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   input  logic            br_taken,
   output logic            stall_if,
   output logic            stall_id,
   output logic            stall_ex,
   output logic            bubble_ex,
   output logic            flush_id,
   output logic [NREG-1:0] pending,
   output logic [0:0]      state_dbg
`ifdef HAZARD_PERF_EN
   ,
   output logic [15:0]     perf_stall_cyc,
   output logic [15:0]     perf_flush_cnt
`endif
);

   logic [0:0] state_q;
   logic [0:0] state_d;

   logic mem_busy;
   logic load_use;
   logic branch_load;
   logic issue;

   logic [NREG-1:0] inc_vec;
   logic [NREG-1:0] dec_vec;
   logic [NREG-1:0] nz_vec;

   assign mem_busy = mem_req & ~mem_ready;

   assign load_use = ex_valid & ex_is_load &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) |
                      (id_use_rs2 & (id_rs2 == ex_rd)));

   assign branch_load = id_is_branch & mem_is_load & mem_busy &
                        ((id_rs1 == mem_rd) | (id_rs2 == mem_rd));

   // Outputs are held low while Reset is asserted so the pipeline sees a
   // clean idle immediately, without waiting for a clock edge.
   always_comb begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      stall_ex  = 1'b0;
      bubble_ex = 1'b0;
      flush_id  = 1'b0;
      state_d   = state_q;
      if (!Reset) begin
         case (state_q)
            ST_RUN: begin
               if (mem_busy || branch_load) begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
                  stall_ex = 1'b1;
                  state_d  = ST_MEMWAIT;
               end else if (br_taken) begin
                  flush_id  = 1'b1;
                  bubble_ex = 1'b1;
               end else if (load_use) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  bubble_ex = 1'b1;
               end
            end
            ST_MEMWAIT: begin
               // EX is frozen here, so a taken branch will be re-presented later.
               if (!mem_ready) begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
                  stall_ex = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign issue = id_valid & id_wr & ~stall_id & ~flush_id;

   for (genvar r = 0; r < NREG; r++) begin : g_pend
      assign inc_vec[r] = issue & (id_rd == AW'(r));
      assign dec_vec[r] = wb_valid & (wb_rd == AW'(r));

      pend_counter u_cnt (
         .clk     (CLK),
         .rst     (Reset),
         .inc     (inc_vec[r]),
         .dec     (dec_vec[r]),
         .nonzero (nz_vec[r])
      );
   end

   assign pending   = nz_vec;
   assign state_dbg = state_q;

`ifdef HAZARD_PERF_EN
   logic [15:0] perf_stall_q;
   logic [15:0] perf_stall_d;
   logic [15:0] perf_flush_q;
   logic [15:0] perf_flush_d;

   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_flush_d = perf_flush_q;
      if (stall_if && (perf_stall_q != 16'hFFFF)) begin
         perf_stall_d = perf_stall_q + 16'd1;
      end
      if (flush_id && (perf_flush_q != 16'hFFFF)) begin
         perf_flush_d = perf_flush_q + 16'd1;
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         perf_stall_q <= 16'd0;
         perf_flush_q <= 16'd0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_stall_cyc = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: combinational vector table plus
// hand-written multi-cycle sequences, checked through an expected-value queue.
module tb_hazard_scoreboard;

   localparam logic O = 1'b1;
   localparam logic Z = 1'b0;

   logic       CLK;
   logic       Reset;
   logic       id_valid;
   logic [2:0] id_rs1;
   logic [2:0] id_rs2;
   logic [2:0] id_rd;
   logic       id_use_rs1;
   logic       id_use_rs2;
   logic       id_wr;
   logic       id_is_branch;
   logic       ex_valid;
   logic       ex_is_load;
   logic [2:0] ex_rd;
   logic       mem_is_load;
   logic [2:0] mem_rd;
   logic       mem_req;
   logic       mem_ready;
   logic       wb_valid;
   logic [2:0] wb_rd;
   logic       br_taken;
   logic       stall_if;
   logic       stall_id;
   logic       stall_ex;
   logic       bubble_ex;
   logic       flush_id;
   logic [7:0] pending;
   logic [0:0] state_dbg;
`ifdef HAZARD_PERF_EN
   logic [15:0] perf_stall_cyc;
   logic [15:0] perf_flush_cnt;
`endif

   hazard_scoreboard dut (
      .CLK          (CLK),
      .Reset        (Reset),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rd        (id_rd),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .id_wr        (id_wr),
      .id_is_branch (id_is_branch),
      .ex_valid     (ex_valid),
      .ex_is_load   (ex_is_load),
      .ex_rd        (ex_rd),
      .mem_is_load  (mem_is_load),
      .mem_rd       (mem_rd),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .br_taken     (br_taken),
      .stall_if     (stall_if),
      .stall_id     (stall_id),
      .stall_ex     (stall_ex),
      .bubble_ex    (bubble_ex),
      .flush_id     (flush_id),
      .pending      (pending),
      .state_dbg    (state_dbg)
`ifdef HAZARD_PERF_EN
      ,
      .perf_stall_cyc (perf_stall_cyc),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   // Clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Scoreboard: {stall_if, stall_id, stall_ex, bubble_ex, flush_id, pending, state}
   logic [13:0] exp_q[$];
   int errors = 0;
   int checks = 0;
   int cnt_m[8];

   function automatic logic [7:0] model_pend();
      logic [7:0] p;
      for (int r = 0; r < 8; r++) p[r] = (cnt_m[r] != 0);
      return p;
   endfunction

   task automatic check_now(input string name);
      logic [13:0] e;
      logic [13:0] a;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: expected queue empty", name);
         return;
      end
      e = exp_q.pop_front();
      a = {stall_if, stall_id, stall_ex, bubble_ex, flush_id, pending, state_dbg};
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got ctl=%b pend=%h st=%b, want ctl=%b pend=%h st=%b",
                  name, a[13:9], a[8:1], a[0], e[13:9], e[8:1], e[0]);
      end
   endtask

   // Driver: one clock cycle with the current inputs, expecting ectl/est.
   task automatic cycle(input logic [4:0] ectl, input logic est, input string name);
      logic iss;
      exp_q.push_back({ectl, model_pend(), est});
      @(negedge CLK);
      check_now(name);
      iss = id_valid & id_wr & ~ectl[3] & ~ectl[0];
      for (int r = 0; r < 8; r++) begin
         logic inc;
         logic dec;
         inc = iss && (id_rd == 3'(r));
         dec = wb_valid && (wb_rd == 3'(r));
         if (inc && !dec && cnt_m[r] < 3) cnt_m[r]++;
         else if (dec && !inc && cnt_m[r] > 0) cnt_m[r]--;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic clr_in();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; id_wr = 0; id_is_branch = 0;
      ex_valid = 0; ex_is_load = 0; ex_rd = 0;
      mem_is_load = 0; mem_rd = 0; mem_req = 0; mem_ready = 0;
      wb_valid = 0; wb_rd = 0; br_taken = 0;
   endtask

   typedef struct {
      logic       ex_valid;
      logic       ex_is_load;
      logic [2:0] ex_rd;
      logic [2:0] id_rs1;
      logic [2:0] id_rs2;
      logic       use1;
      logic       use2;
      logic       br;
      logic       is_br;
      logic       mem_ld;
      logic [2:0] mem_rd;
      logic       mem_req;
      logic       mem_rdy;
      logic [4:0] exp;
      string      name;
   } vec_t;

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{Z, Z, 3'd0, 3'd0, 3'd0, Z, Z, Z, Z, Z, 3'd0, Z, Z, 5'b00000, "idle"};
      tbl[1]  = '{O, O, 3'd3, 3'd3, 3'd0, O, Z, Z, Z, Z, 3'd0, Z, Z, 5'b11010, "lu_rs1"};
      tbl[2]  = '{O, O, 3'd4, 3'd1, 3'd4, Z, O, Z, Z, Z, 3'd0, Z, Z, 5'b11010, "lu_rs2"};
      tbl[3]  = '{O, O, 3'd3, 3'd3, 3'd3, Z, Z, Z, Z, Z, 3'd0, Z, Z, 5'b00000, "no_use"};
      tbl[4]  = '{O, Z, 3'd3, 3'd3, 3'd0, O, Z, Z, Z, Z, 3'd0, Z, Z, 5'b00000, "not_load"};
      tbl[5]  = '{Z, O, 3'd3, 3'd3, 3'd0, O, Z, Z, Z, Z, 3'd0, Z, Z, 5'b00000, "ex_invalid"};
      tbl[6]  = '{O, O, 3'd3, 3'd3, 3'd0, O, Z, O, Z, Z, 3'd0, Z, Z, 5'b00011, "br_over_lu"};
      tbl[7]  = '{Z, Z, 3'd0, 3'd0, 3'd0, Z, Z, O, Z, Z, 3'd0, Z, Z, 5'b00011, "br_alone"};
      tbl[8]  = '{O, O, 3'd0, 3'd0, 3'd7, O, Z, Z, Z, Z, 3'd0, Z, Z, 5'b11010, "lu_r0"};
      tbl[9]  = '{Z, Z, 3'd0, 3'd0, 3'd0, Z, Z, Z, Z, Z, 3'd0, O, O, 5'b00000, "mem_done_now"};
      tbl[10] = '{Z, Z, 3'd0, 3'd0, 3'd6, Z, Z, Z, O, O, 3'd6, O, O, 5'b00000, "bl_not_busy"};
      tbl[11] = '{O, O, 3'd3, 3'd2, 3'd5, O, O, Z, Z, Z, 3'd0, Z, Z, 5'b00000, "lu_mismatch"};

      for (int r = 0; r < 8; r++) cnt_m[r] = 0;
      clr_in();
      Reset = 1'b1;
      #1;
      exp_q.push_back(14'd0);
      check_now("reset_state");
      @(posedge CLK);
      @(negedge CLK);
      Reset = 1'b0;
      @(posedge CLK);
      #1;

      // Combinational vector table (all in RUN, no register writes)
      for (int i = 0; i < 12; i++) begin
         clr_in();
         ex_valid = tbl[i].ex_valid;   ex_is_load = tbl[i].ex_is_load;
         ex_rd = tbl[i].ex_rd;         id_rs1 = tbl[i].id_rs1;
         id_rs2 = tbl[i].id_rs2;       id_use_rs1 = tbl[i].use1;
         id_use_rs2 = tbl[i].use2;     br_taken = tbl[i].br;
         id_is_branch = tbl[i].is_br;  mem_is_load = tbl[i].mem_ld;
         mem_rd = tbl[i].mem_rd;       mem_req = tbl[i].mem_req;
         mem_ready = tbl[i].mem_rdy;
         cycle(tbl[i].exp, 1'b0, tbl[i].name);
      end

      // Load-use: one stall cycle, then EX holds the bubble
      clr_in();
      ex_valid = 1; ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
      cycle(5'b11010, 1'b0, "lu_stall");
      ex_valid = 0;
      cycle(5'b00000, 1'b0, "lu_release");

      // Memory wait with a taken branch ignored while waiting
      clr_in();
      mem_req = 1;
      cycle(5'b11100, 1'b0, "mw_c1");
      cycle(5'b11100, 1'b1, "mw_c2");
      br_taken = 1;
      cycle(5'b11100, 1'b1, "mw_br_ignored");
      br_taken = 0;
      cycle(5'b11100, 1'b1, "mw_c4");
      mem_ready = 1; br_taken = 1;
      cycle(5'b00000, 1'b1, "mw_ready");
      clr_in();
      cycle(5'b00000, 1'b0, "mw_back_run");

      // Pending-write scoreboard on r5
      id_valid = 1; id_wr = 1; id_rd = 5;
      cycle(5'b00000, 1'b0, "sb_iss1");
      cycle(5'b00000, 1'b0, "sb_iss2");
      cycle(5'b00000, 1'b0, "sb_iss3");
      cycle(5'b00000, 1'b0, "sb_iss_sat");
      id_valid = 0; wb_valid = 1; wb_rd = 5;
      cycle(5'b00000, 1'b0, "sb_ret1");
      cycle(5'b00000, 1'b0, "sb_ret2");
      cycle(5'b00000, 1'b0, "sb_ret3");
      cycle(5'b00000, 1'b0, "sb_ret_underflow");
      wb_valid = 0; id_valid = 1;
      cycle(5'b00000, 1'b0, "sb_iss_after");
      wb_valid = 1;
      cycle(5'b00000, 1'b0, "sb_both");
      id_valid = 0; wb_valid = 0;
      cycle(5'b00000, 1'b0, "sb_hold");
      wb_valid = 1;
      cycle(5'b00000, 1'b0, "sb_ret_last");
      wb_valid = 0;
      cycle(5'b00000, 1'b0, "sb_empty");

      // Issue suppressed by a stall and by a flush
      clr_in();
      id_valid = 1; id_wr = 1; id_rd = 2;
      ex_valid = 1; ex_is_load = 1; ex_rd = 1; id_rs1 = 1; id_use_rs1 = 1;
      cycle(5'b11010, 1'b0, "sb_stall_blk");
      ex_valid = 0; br_taken = 1;
      cycle(5'b00011, 1'b0, "sb_flush_blk");
      clr_in();
      cycle(5'b00000, 1'b0, "sb_no_issue");

      // Branch compare waiting on load data
      id_is_branch = 1; id_rs2 = 6; id_rs1 = 1; mem_is_load = 1; mem_rd = 6;
      mem_req = 1;
      cycle(5'b11100, 1'b0, "bl_c1");
      cycle(5'b11100, 1'b1, "bl_c2");
      mem_ready = 1;
      cycle(5'b00000, 1'b1, "bl_ready");
      clr_in();
      cycle(5'b00000, 1'b0, "bl_run");

      // Asynchronous reset in MEMWAIT with pending = 0x24
      id_valid = 1; id_wr = 1; id_rd = 2;
      cycle(5'b00000, 1'b0, "rst_iss_r2");
      id_rd = 5;
      cycle(5'b00000, 1'b0, "rst_iss_r5");
      clr_in();
      mem_req = 1;
      cycle(5'b11100, 1'b0, "rst_pre_c1");
      cycle(5'b11100, 1'b1, "rst_pre_c2");
      #2;
      Reset = 1'b1;
      #1;
      for (int r = 0; r < 8; r++) cnt_m[r] = 0;
      exp_q.push_back(14'd0);
      check_now("rst_async");
      @(posedge CLK);
      @(negedge CLK);
      Reset = 1'b0;
      clr_in();
      @(posedge CLK);
      #1;
      cycle(5'b00000, 1'b0, "rst_after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
